// File: rtl/alu_fun_dispatch.sv
// ALU function dispatcher: registers a function request, enables one unit,
// and reports completion, illegal selects or timeout.
module alu_fun_dispatch #(
  parameter int FUN_WIDTH = 4,
  parameter int SEL_WIDTH = 2,
  parameter int N_UNITS   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           FUN_VALID,
  output logic                           FUN_READY,
  input  logic [FUN_WIDTH-1:0]           ALU_FUN,
  input  logic [N_UNITS-1:0]             UNIT_DONE,
  output logic [N_UNITS-1:0]             UNIT_EN,
  output logic [FUN_WIDTH-SEL_WIDTH-1:0] UNIT_FUN,
  output logic                           BUSY,
  output logic                           OUT_VALID,
  output logic [SEL_WIDTH-1:0]           OUT_UNIT,
  output logic                           ILLEGAL,
  output logic                           TIMEOUT_ERR
);

  localparam int SUB_W = FUN_WIDTH - SEL_WIDTH;
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [N_UNITS-1:0]   en_q, en_d;
  logic [SUB_W-1:0]     fun_q, fun_d;
  logic                 busy_q, busy_d;
  logic                 ov_q, ov_d;
  logic [SEL_WIDTH-1:0] ou_q, ou_d;
  logic                 ill_q, ill_d;
  logic                 to_q, to_d;

  logic [SEL_WIDTH-1:0] sel;
  logic                 sel_ok;
  logic [N_UNITS-1:0]   onehot;
  logic                 hit;
  logic                 expired;

  assign sel     = ALU_FUN[FUN_WIDTH-1 -: SEL_WIDTH];
  assign sel_ok  = 32'(sel) < N_UNITS;
  // The enable is one-hot on the active unit, so masking picks its strobe.
  assign hit     = |(UNIT_DONE & en_q);
  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_UNITS; i++)
      onehot[i] = (32'(sel) == i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    fun_d   = fun_q;
    busy_d  = busy_q;
    ov_d    = 1'b0;
    ou_d    = ou_q;
    ill_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (FUN_VALID) begin
          if (sel_ok) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            sel_d   = sel;
            en_d    = onehot;
            fun_d   = ALU_FUN[SUB_W-1:0];
            busy_d  = 1'b1;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (hit) begin
          state_d = IDLE;
          en_d    = '0;
          busy_d  = 1'b0;
          ov_d    = 1'b1;
          ou_d    = sel_q;
        end else if (expired) begin
          state_d = IDLE;
          en_d    = '0;
          busy_d  = 1'b0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= '0;
      fun_q   <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      ou_q    <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      fun_q   <= fun_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      ou_q    <= ou_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  assign FUN_READY   = (state_q == IDLE);
  assign UNIT_EN     = en_q;
  assign UNIT_FUN    = fun_q;
  assign BUSY        = busy_q;
  assign OUT_VALID   = ov_q;
  assign OUT_UNIT    = ou_q;
  assign ILLEGAL     = ill_q;
  assign TIMEOUT_ERR = to_q;

endmodule

// File: tb/tb_alu_fun_dispatch.sv
// Bench for alu_fun_dispatch: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_alu_fun_dispatch;

  logic       CLK;
  logic       RST;
  logic       FUN_VALID;
  logic       FUN_READY;
  logic [3:0] ALU_FUN;
  logic [2:0] UNIT_DONE;
  logic [2:0] UNIT_EN;
  logic [1:0] UNIT_FUN;
  logic       BUSY;
  logic       OUT_VALID;
  logic [1:0] OUT_UNIT;
  logic       ILLEGAL;
  logic       TIMEOUT_ERR;

  int n_checks = 0;
  int n_errors = 0;

  alu_fun_dispatch #(
    .FUN_WIDTH(4),
    .SEL_WIDTH(2),
    .N_UNITS(3),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .FUN_VALID(FUN_VALID),
    .FUN_READY(FUN_READY),
    .ALU_FUN(ALU_FUN),
    .UNIT_DONE(UNIT_DONE),
    .UNIT_EN(UNIT_EN),
    .UNIT_FUN(UNIT_FUN),
    .BUSY(BUSY),
    .OUT_VALID(OUT_VALID),
    .OUT_UNIT(OUT_UNIT),
    .ILLEGAL(ILLEGAL),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    FUN_VALID = 1'b0;
    ALU_FUN = '0;
    UNIT_DONE = '0;
    #3 RST = 1'b1;
    #2;
    n_checks++;
    if ({UNIT_EN, UNIT_FUN, BUSY, OUT_VALID, OUT_UNIT, ILLEGAL, TIMEOUT_ERR, FUN_READY} !== 12'h001) begin
      n_errors++;
      $display("FAIL reset_outputs got %b want 000000000001",
               {UNIT_EN, UNIT_FUN, BUSY, OUT_VALID, OUT_UNIT, ILLEGAL, TIMEOUT_ERR, FUN_READY});
    end
    tick();
    RST = 1'b0;
    tick();
    n_checks++;
    if (UNIT_EN !== 3'b000 || BUSY !== 1'b0 || FUN_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_idle got en=%b busy=%b rdy=%b want 000/0/1", UNIT_EN, BUSY, FUN_READY);
    end
  endtask

  task automatic test_basic;
    FUN_VALID = 1'b1;
    ALU_FUN = 4'b0110;
    tick();
    FUN_VALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (UNIT_EN !== 3'b010 || UNIT_FUN !== 2'b10 || BUSY !== 1'b1 || FUN_READY !== 1'b0) begin
        n_errors++;
        $display("FAIL basic_active c%0d got en=%b fun=%b busy=%b rdy=%b want 010/10/1/0",
                 c, UNIT_EN, UNIT_FUN, BUSY, FUN_READY);
      end
      if (c == 3) UNIT_DONE = 3'b010;
      tick();
    end
    UNIT_DONE = '0;
    n_checks++;
    if (UNIT_EN !== 3'b000 || OUT_VALID !== 1'b1 || OUT_UNIT !== 2'd1 || FUN_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_done got en=%b ov=%b ou=%0d rdy=%b want 000/1/1/1",
               UNIT_EN, OUT_VALID, OUT_UNIT, FUN_READY);
    end
    tick();
    n_checks++;
    if (OUT_VALID !== 1'b0 || UNIT_FUN !== 2'b10) begin
      n_errors++;
      $display("FAIL basic_after got ov=%b fun=%b want 0/10", OUT_VALID, UNIT_FUN);
    end
  endtask

  task automatic test_illegal;
    FUN_VALID = 1'b1;
    ALU_FUN = 4'b1101;
    tick();
    FUN_VALID = 1'b0;
    n_checks++;
    if (ILLEGAL !== 1'b1 || UNIT_EN !== 3'b000 || BUSY !== 1'b0 || FUN_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_pulse got ill=%b en=%b busy=%b rdy=%b want 1/000/0/1",
               ILLEGAL, UNIT_EN, BUSY, FUN_READY);
    end
    tick();
    n_checks++;
    if (ILLEGAL !== 1'b0 || FUN_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_once got ill=%b rdy=%b want 0/1", ILLEGAL, FUN_READY);
    end
  endtask

  task automatic test_timeout(input bit late_done);
    FUN_VALID = 1'b1;
    ALU_FUN = 4'b0000;
    tick();
    FUN_VALID = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (UNIT_EN !== 3'b001 || TIMEOUT_ERR !== 1'b0 || OUT_VALID !== 1'b0) begin
        n_errors++;
        $display("FAIL tmo_hold c%0d got en=%b to=%b ov=%b want 001/0/0",
                 c, UNIT_EN, TIMEOUT_ERR, OUT_VALID);
      end
      if (c == 8 && late_done) UNIT_DONE = 3'b001;
      tick();
    end
    UNIT_DONE = '0;
    n_checks++;
    if (UNIT_EN !== 3'b000 || BUSY !== 1'b0 || TIMEOUT_ERR !== !late_done || OUT_VALID !== late_done) begin
      n_errors++;
      $display("FAIL tmo_end late=%0d got en=%b busy=%b to=%b ov=%b want 000/0/%0d/%0d",
               late_done, UNIT_EN, BUSY, TIMEOUT_ERR, OUT_VALID, !late_done, late_done);
    end
    tick();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0 || OUT_VALID !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_once got to=%b ov=%b want 0/0", TIMEOUT_ERR, OUT_VALID);
    end
  endtask

  task automatic test_wrong_unit;
    FUN_VALID = 1'b1;
    ALU_FUN = 4'b1000;
    tick();
    UNIT_DONE = 3'b001;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (UNIT_EN !== 3'b100 || OUT_VALID !== 1'b0 || FUN_READY !== 1'b0) begin
        n_errors++;
        $display("FAIL wrong_hold c%0d got en=%b ov=%b rdy=%b want 100/0/0",
                 c, UNIT_EN, OUT_VALID, FUN_READY);
      end
      tick();
    end
    n_checks++;
    if (UNIT_EN !== 3'b100) begin
      n_errors++;
      $display("FAIL wrong_last got en=%b want 100", UNIT_EN);
    end
    UNIT_DONE = 3'b100;
    tick();
    UNIT_DONE = '0;
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_UNIT !== 2'd2 || UNIT_EN !== 3'b000) begin
      n_errors++;
      $display("FAIL wrong_done got ov=%b ou=%0d en=%b want 1/2/000", OUT_VALID, OUT_UNIT, UNIT_EN);
    end
    tick();
    FUN_VALID = 1'b0;
    n_checks++;
    if (UNIT_EN !== 3'b100 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL held_req got en=%b busy=%b want 100/1", UNIT_EN, BUSY);
    end
    UNIT_DONE = 3'b100;
    tick();
    UNIT_DONE = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    FUN_VALID = 1'b1;
    ALU_FUN = 4'b0001;
    tick();
    FUN_VALID = 1'b0;
    n_checks++;
    if (UNIT_EN !== 3'b001) begin
      n_errors++;
      $display("FAIL rst_pre got en=%b want 001", UNIT_EN);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (UNIT_EN !== 3'b000 || BUSY !== 1'b0 || FUN_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_async got en=%b busy=%b rdy=%b want 000/0/1", UNIT_EN, BUSY, FUN_READY);
    end
    tick();
    n_checks++;
    if (OUT_VALID !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_nopulse got ov=%b to=%b want 0/0", OUT_VALID, TIMEOUT_ERR);
    end
    RST = 1'b0;
    FUN_VALID = 1'b1;
    ALU_FUN = 4'b0100;
    tick();
    FUN_VALID = 1'b0;
    n_checks++;
    if (UNIT_EN !== 3'b010 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_accept got en=%b busy=%b want 010/1", UNIT_EN, BUSY);
    end
    UNIT_DONE = 3'b010;
    tick();
    UNIT_DONE = '0;
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_UNIT !== 2'd1) begin
      n_errors++;
      $display("FAIL rst_done got ov=%b ou=%0d want 1/1", OUT_VALID, OUT_UNIT);
    end
    tick();
  endtask

  task automatic test_random;
    bit m_busy = 0;
    int m_unit = 0;
    int m_age  = 0;
    int m_sub  = 0;
    bit e_ov, e_ill, e_to;
    int s;
    bit [2:0] e_en;
    for (int n = 0; n < 400; n++) begin
      FUN_VALID = ($urandom_range(0, 1) == 1);
      ALU_FUN = 4'($urandom);
      UNIT_DONE = '0;
      for (int b = 0; b < 3; b++)
        UNIT_DONE[b] = ($urandom_range(0, 5) == 0);
      tick();
      e_ov = 0;
      e_ill = 0;
      e_to = 0;
      if (!m_busy) begin
        if (FUN_VALID) begin
          s = int'(ALU_FUN) / 4;
          if (s < 3) begin
            m_busy = 1;
            m_unit = s;
            m_age = 0;
            m_sub = int'(ALU_FUN) % 4;
          end else begin
            e_ill = 1;
          end
        end
      end else if (UNIT_DONE[m_unit]) begin
        m_busy = 0;
        e_ov = 1;
      end else if (m_age == 7) begin
        m_busy = 0;
        e_to = 1;
      end else begin
        m_age++;
      end
      e_en = m_busy ? 3'(1 << m_unit) : 3'b000;
      n_checks++;
      if (UNIT_EN !== e_en || BUSY !== m_busy || FUN_READY !== !m_busy ||
          OUT_VALID !== e_ov || ILLEGAL !== e_ill || TIMEOUT_ERR !== e_to ||
          (m_busy && UNIT_FUN !== 2'(m_sub)) || (e_ov && OUT_UNIT !== 2'(m_unit))) begin
        n_errors++;
        $display("FAIL rand n%0d got en=%b busy=%b rdy=%b ov=%b ill=%b to=%b fun=%0d ou=%0d want en=%b busy=%b ov=%b ill=%b to=%b fun=%0d unit=%0d",
                 n, UNIT_EN, BUSY, FUN_READY, OUT_VALID, ILLEGAL, TIMEOUT_ERR, UNIT_FUN, OUT_UNIT,
                 e_en, m_busy, e_ov, e_ill, e_to, m_sub, m_unit);
      end
    end
    FUN_VALID = 1'b0;
    UNIT_DONE = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_wrong_unit();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
